// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation encodings and controller states.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Two's-complement helper: passes the value through, or negates it when asked.
// Used both to take operand magnitudes and to restore the sign of results.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] result_o
);

  assign result_o = negate_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply and restoring divide, one radix-2 step per clock.
// Optional build macro EARLY_TERM_EN lets multiplies leave CALC once the multiplier is exhausted.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  mdu_op_e            op_in;
  logic               in_signed;
  logic               in_div;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               is_div_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic               early_exit;

  assign op_in     = mdu_op_e'(op);
  assign in_signed = (op_in == MDU_MULT) || (op_in == MDU_DIV);
  assign in_div    = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
  assign is_div_q  = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

  mdu_sign_fix #(.W(WIDTH)) u_mag_a (
    .value_i  (a),
    .negate_i (in_signed & a[WIDTH-1]),
    .result_o (mag_a)
  );

  mdu_sign_fix #(.W(WIDTH)) u_mag_b (
    .value_i  (b),
    .negate_i (in_signed & b[WIDTH-1]),
    .result_o (mag_b)
  );

  // Shift-add: the upper half collects partial sums while the multiplier drains out of the lower half.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide: the shifted remainder needs one extra bit before the trial subtract.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef EARLY_TERM_EN
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  // Unconsumed multiplier bits sit in the low WIDTH-cnt bits; the skipped steps become one shift.
  assign early_exit = !is_div_q && (cnt_q != '0) &&
                      ((acc_q[WIDTH-1:0] & (ALL_ONES >> cnt_q)) == '0);
  assign mul_prod   = acc_q >> (FULL_CNT - cnt_q);
`else
  assign early_exit = 1'b0;
  assign mul_prod   = acc_q;
`endif

  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .value_i  (mul_prod),
    .negate_i (neg_res_q),
    .result_o (prod_fixed)
  );

  mdu_sign_fix #(.W(WIDTH)) u_fix_quot (
    .value_i  (acc_q[WIDTH-1:0]),
    .negate_i (neg_res_q),
    .result_o (quot_fixed)
  );

  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .value_i  (acc_q[2*WIDTH-1:WIDTH]),
    .negate_i (neg_rem_q),
    .result_o (rem_fixed)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op_in;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          if (in_div && (b == '0)) begin
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            mcand_d   = in_div ? mag_b : mag_a;
            acc_d     = {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
            neg_res_d = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = (op_in == MDU_DIV) & a[WIDTH-1];
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        if (early_exit) begin
          state_d = FIX;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fixed;
          lo_d = quot_fixed;
        end else begin
          hi_d = prod_fixed[2*WIDTH-1:WIDTH];
          lo_d = prod_fixed[WIDTH-1:0];
        end
        state_d = DONE;
      end

      DONE: begin
        div_zero_d = 1'b0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= MDU_MULT;
      acc_q      <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign div_zero = (state_q == DONE) && div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32) with hand-computed results.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int passCount  = 0;
  int checkCount = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Issues one request and counts edges after the accepting edge until done is seen.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                               output int edges, output logic sawBusy);
    op      = opIn;
    a       = aIn;
    b       = bIn;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    edges   = 0;
    sawBusy = 1'b0;
    while (!done && edges < 100) begin
      sawBusy = sawBusy | busy;
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  initial begin
    int   edges;
    logic sawBusy;
    int   doneCount;
    logic sawDz;
    int   expEdges;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    checkOutput("reset_dz", {31'b0, div_zero}, 32'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, edges, sawBusy);
    checkOutput("mult_latency", edges, 32'd33);
    checkOutput("mult_busy", {31'b0, sawBusy}, 32'h1);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFEB);
    checkOutput("mult_dz", {31'b0, div_zero}, 32'h0);
    @(posedge clock);
    #1;
    checkOutput("done_one_cycle", {31'b0, done}, 32'h0);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, sawBusy);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);
    @(posedge clock);
    #1;

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, edges, sawBusy);
    checkOutput("div_latency", edges, 32'd33);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);
    @(posedge clock);
    #1;

    applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE, edges, sawBusy);
    checkOutput("div_negdiv_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_negdiv_hi", hi, 32'h0000_0001);
    @(posedge clock);
    #1;

    applyStimulus(OP_DIVU, 32'd7, 32'd2, edges, sawBusy);
    checkOutput("divu_lo", lo, 32'd3);
    checkOutput("divu_hi", hi, 32'd1);
    @(posedge clock);
    #1;

    applyStimulus(OP_DIV, 32'd5, 32'd0, edges, sawBusy);
    checkOutput("dz_latency", edges, 32'd0);
    checkOutput("dz_flag", {31'b0, div_zero}, 32'h1);
    checkOutput("dz_busy", {31'b0, sawBusy}, 32'h0);
    checkOutput("dz_hi_kept", hi, 32'd1);
    checkOutput("dz_lo_kept", lo, 32'd3);
    @(posedge clock);
    #1;
    checkOutput("dz_flag_clear", {31'b0, div_zero}, 32'h0);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, edges, sawBusy);
    checkOutput("div_minneg_lo", lo, 32'h8000_0000);
    checkOutput("div_minneg_hi", hi, 32'h0);
    @(posedge clock);
    #1;

    // Reset in the middle of a MULTU: everything clears immediately and no done follows.
    op    = OP_MULTU;
    a     = 32'd1234;
    b     = 32'd5678;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    checkOutput("pre_reset_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_hi", hi, 32'h0);
    checkOutput("midreset_lo", lo, 32'h0);
    checkOutput("midreset_busy", {31'b0, busy}, 32'h0);
    checkOutput("midreset_done", {31'b0, done}, 32'h0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done) doneCount++;
    end
    checkOutput("midreset_no_done", doneCount, 32'd0);

    applyStimulus(OP_MULT, 32'd6, 32'd7, edges, sawBusy);
    checkOutput("after_reset_lo", lo, 32'd42);
    checkOutput("after_reset_hi", hi, 32'd0);
    @(posedge clock);
    #1;

    // A start pulse while busy (a divide-by-zero request) must be ignored.
    op    = OP_MULTU;
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    op    = OP_DIVU;
    a     = 32'd100;
    b     = 32'd0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    doneCount = 0;
    sawDz     = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) doneCount++;
      sawDz = sawDz | div_zero;
      @(posedge clock);
      #1;
    end
    checkOutput("ignore_start_dones", doneCount, 32'd1);
    checkOutput("ignore_start_dz", {31'b0, sawDz}, 32'h0);
    checkOutput("ignore_start_lo", lo, 32'd15);

`ifdef EARLY_TERM_EN
    expEdges = 3;
`else
    expEdges = 33;
`endif
    applyStimulus(OP_MULTU, 32'd5, 32'd1, edges, sawBusy);
    checkOutput("multu_small_latency", edges, expEdges);
    checkOutput("multu_small_lo", lo, 32'd5);
    checkOutput("multu_small_hi", hi, 32'd0);
    @(posedge clock);
    #1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised multi-cycle multiply/divide unit that produces HI/LO for the multicycle CPU datapath.
- Supports signed and unsigned multiply and divide through an op select.
- Uses a start/busy/done handshake so the control unit can stall in a wait state.
- Operates on operand magnitudes with a final sign-correction step; one radix-2 step per clock.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; supported range is 4 or more.
CNT_W, $clog2(WIDTH+1), step-counter width (derived; not overridden).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
a  input  WIDTH  multiplicand / dividend (RegA)
b  input  WIDTH  multiplier / divisor (RegB)
busy  output  1  high in CALC and FIX
done  output  1  one-cycle pulse; hi/lo are valid while it is high
div_zero  output  1  high together with done when a DIV/DIVU had b==0
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - hi, lo, the counter and all internal registers clear to 0.
  - busy, done and div_zero go to 0.
  - Reset mid-operation aborts the operation; no partial result is written.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge E0:
  - Latch op, |a|, |b| (magnitudes only for signed ops), the sign of the result and the sign of the remainder.
  - Clear the counter, go to CALC.
- Divide by zero: DIV/DIVU with b==0 at E0 goes directly to DONE.
  - div_zero=1 and done=1.
  - hi/lo are unchanged.
- CALC, one step per edge E1..E_WIDTH:
  - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand to the upper half, then shift the 2*WIDTH accumulator right by one.
  - Divide: restoring division. Shift {rem,quot} left, trial-subtract the divisor, and set the quotient LSB when the result is non-negative.
  - After WIDTH steps, go to FIX.
- FIX, edge E_WIDTH+1:
  - Apply sign correction.
    - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
    - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write hi/lo and go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE on the next edge.
- Latency and throughput: done is high in the cycle after E_WIDTH+1; with WIDTH=32 that is after 33 edges. Next start is accepted in IDLE, giving a throughput of WIDTH+3 cycles per operation.
- start is ignored while in CALC, FIX or DONE; a held start in IDLE restarts the unit.
- Signed DIV of the most negative value by -1 gives quotient 0x80000000 (wraps) and remainder 0.
- hi/lo hold their last result until the next completed operation.

Optional Feature:
EARLY_TERM_EN
- Defined: multiply leaves CALC as soon as the unshifted remaining multiplier bits are all zero, with a minimum of 1 CALC step. The accumulator is realigned by the remaining shift count in FIX. Divide latency is unchanged.
- Not defined: multiply always takes WIDTH CALC steps.

Decomposition:
- mdu_pkg holds:
  - mdu_op_e enum (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU).
  - mdu_state_e enum (IDLE, CALC, FIX, DONE).
- One natural sub-module: mdu_sign_fix, a combinational two's-complement magnitude/negate helper. It is instantiated for operand magnitude at E0 and for result correction in FIX.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7 -> done after 33 edges; hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=5, b=0 -> done and div_zero in the cycle after E0; hi/lo keep their prior values; busy never asserted.
- Assert reset at step 10 of a MULTU -> all outputs 0 immediately; no done; a fresh MULT 6*7 afterwards gives lo=42, hi=0.
- start pulsed while busy -> ignored, single done. With EARLY_TERM_EN, MULTU 5*1 gives done 3 edges after E0, lo=5.
